// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the seven-segment scan controller: digit codes,
// display geometry and the conversion FSM state type.
package seg_pkg;

    localparam logic [4:0] SEG_BLANK  = 5'h10;
    localparam logic [4:0] SEG_DASH   = 5'h11;
    localparam int         NUM_DIGITS = 4;
    localparam int         BCD_MAX    = 9999;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } conv_state_e;

    // Double-dabble correction: a nibble of 5 or more becomes >= 8 after +3,
    // so the following left shift carries correctly into the next decade.
    function automatic logic [3:0] dabble_adjust(input logic [3:0] nib);
        return (nib >= 4'd5) ? (nib + 4'd3) : nib;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Application-side bundle of the scan controller: load request, blanking
// control, busy status and the multiplexed anode/digit outputs.
interface seg_scan_ctrl_if #(
    parameter int BIN_W = 14
);
    logic [BIN_W-1:0] value;
    logic             load;
    logic             blank_lz;
    logic             busy;
    logic [3:0]       AN;
    logic [4:0]       digit;

    // Application logic / test driver side.
    modport master (
        output value, load, blank_lz,
        input  busy, AN, digit
    );

    // Scan controller side.
    modport slave (
        input  value, load, blank_lz,
        output busy, AN, digit
    );
endinterface

// File: rtl/seg_scan_ctrl_bin2bcd.sv
// Sequential double-dabble converter: one add-3/shift iteration per clock,
// BIN_W iterations per conversion. The 16-bit BCD result covers 0..9999.
module bin2bcd_seq
    import seg_pkg::*;
#(
    parameter int BIN_W = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [BIN_W-1:0] bin_i,
    output logic [15:0]      bcd_o,
    // High during the cycle whose closing edge performs the final iteration,
    // so the caller can step to its commit state on that same edge.
    output logic             done_o
);

    localparam int CNT_W = $clog2(BIN_W + 1);

    logic [BIN_W-1:0] bin_q, bin_d;
    logic [15:0]      bcd_q, bcd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      bcd_adj;

    // Per-nibble add-3 correction applied before every shift.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = dabble_adjust(bcd_q[gi*4 +: 4]);
        end
    endgenerate

    // Next state: capture on start, otherwise iterate while iterations remain.
    always_comb begin
        bin_d = bin_q;
        bcd_d = bcd_q;
        cnt_d = cnt_q;
        if (start_i) begin
            bin_d = bin_i;
            bcd_d = '0;
            cnt_d = CNT_W'(BIN_W);
        end else if (cnt_q != '0) begin
            {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
            cnt_d          = cnt_q - CNT_W'(1);
        end
    end

    // Engine registers; reset abandons any conversion in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bin_q <= '0;
            bcd_q <= '0;
            cnt_q <= '0;
        end else begin
            bin_q <= bin_d;
            bcd_q <= bcd_d;
            cnt_q <= cnt_d;
        end
    end

    assign bcd_o  = bcd_q;
    assign done_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment scan controller. Converts a loaded binary value
// to BCD, holds it in display registers updated atomically, and scans the
// digits onto the shared bus with active-low anode enables.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter int BIN_W       = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    seg_scan_ctrl_if.slave    bus
);

    localparam int          PRE_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [31:0] BCD_MAX_U = BCD_MAX;

    // ---------------- conversion control ----------------
    conv_state_e      state_q, state_d;
    logic             pend_q, pend_d;
    logic [BIN_W-1:0] pend_val_q, pend_val_d;
    logic             conv_ovf_q, conv_ovf_d;
    logic [15:0]      disp_q, disp_d;
    logic             ovf_q, ovf_d;

    logic             start;
    logic [BIN_W-1:0] start_val;
    logic [15:0]      bcd;
    logic             conv_done;

    bin2bcd_seq #(
        .BIN_W (BIN_W)
    ) u_bin2bcd (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start),
        .bin_i   (start_val),
        .bcd_o   (bcd),
        .done_o  (conv_done)
    );

    // Conversion FSM: start, queue later loads as a single pending value,
    // and publish the result to the display registers in one cycle.
    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        conv_ovf_d = conv_ovf_q;
        disp_d     = disp_q;
        ovf_d      = ovf_q;
        start      = 1'b0;
        start_val  = bus.value;

        case (state_q)
            IDLE: begin
                if (bus.load) begin
                    start   = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.load) begin
                    pend_d     = 1'b1;
                    pend_val_d = bus.value;
                end
                if (conv_done) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                disp_d = bcd;
                ovf_d  = conv_ovf_q;
                // A load arriving in this cycle is treated as the newest
                // pending request and therefore wins over the stored one.
                if (pend_q || bus.load) begin
                    start     = 1'b1;
                    start_val = bus.load ? bus.value : pend_val_q;
                    pend_d    = 1'b0;
                    state_d   = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Out-of-range values are flagged at capture; their BCD is ignored.
        if (start) begin
            conv_ovf_d = (32'(start_val) > BCD_MAX_U);
        end
    end

    // Conversion state and display registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pend_q     <= 1'b0;
            pend_val_q <= '0;
            conv_ovf_q <= 1'b0;
            disp_q     <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
            conv_ovf_q <= conv_ovf_d;
            disp_q     <= disp_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bus.busy = (state_q != IDLE);

    // ---------------- scanning ----------------
    logic [PRE_W-1:0] presc_q, presc_d;
    logic [1:0]       idx_q, idx_d;
    logic             scan_tick;

    assign scan_tick = (presc_q == PRE_W'(REFRESH_DIV - 1));

    // Prescaler and scan index run freely, independent of conversions.
    always_comb begin
        presc_d = scan_tick ? '0 : (presc_q + PRE_W'(1));
        idx_d   = scan_tick ? (idx_q + 2'd1) : idx_q;
    end

    // Prescaler and scan index registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q <= '0;
            idx_q   <= '0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
        end
    end

    // ---------------- digit select ----------------
    // upper_zero[i]: digit i and every more significant digit are zero.
    logic [NUM_DIGITS-1:0] upper_zero;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_upper_zero
            assign upper_zero[gi] = (disp_q[15:gi*4] == '0);
        end
    endgenerate

    logic [3:0] an_q, an_d;
    logic [4:0] digit_q, digit_d;
    logic [3:0] cur_nib;

    assign cur_nib = disp_q[{idx_q, 2'b00} +: 4];

    // Digit code and anode for the current slot, including blanking rules.
    always_comb begin
        an_d = ~(4'b0001 << idx_q);
        if (ovf_q) begin
            digit_d = SEG_DASH;
        end else if (bus.blank_lz && (idx_q != 2'd0) && upper_zero[idx_q]) begin
            digit_d = SEG_BLANK;
        end else begin
            digit_d = {1'b0, cur_nib};
        end
    end

    // Anode and digit share one register stage so they always change together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an_q    <= 4'b1110;
            digit_q <= '0;
        end else begin
            an_q    <= an_d;
            digit_q <= digit_d;
        end
    end

    assign bus.AN    = an_q;
    assign bus.digit = digit_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl. A timeline model (conversion
// latency, pending-load replacement, decimal digit extraction) predicts
// AN, busy and digit after every clock edge.
module tb_seg_scan_ctrl;

    localparam int RDIV = 4;
    localparam int BW   = 14;
    localparam int CONV_EDGES = BW + 1;   // start edge to commit edge

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    seg_scan_ctrl_if #(.BIN_W(BW)) bus ();

    seg_scan_ctrl #(
        .REFRESH_DIV (RDIV),
        .BIN_W       (BW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Model state
    int edge_no      = 0;
    int scan_n       = 0;    // edges since reset release
    bit m_active     = 0;    // a conversion is running
    int m_start_edge = 0;
    int m_conv_val   = 0;
    bit m_pend       = 0;
    int m_pend_val   = 0;
    int m_shown      = 0;    // value visible on the digit output
    int m_next_shown = 0;
    int m_apply_edge = -1;

    function automatic logic [4:0] exp_digit(int v, int slot, bit blz);
        int p;
        p = 1;
        for (int i = 0; i < slot; i++) p = p * 10;
        if (v > 9999) return 5'h11;
        if (blz && (slot != 0) && (v < p)) return 5'h10;
        return 5'((v / p) % 10);
    endfunction

    task automatic check(string tag, logic [15:0] got, logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h at edge %0d", tag, got, exp, edge_no);
        end
    endtask

    // One clock edge: advance the model with the inputs present at the edge,
    // then compare all outputs.
    task automatic tick();
        bit              ld;
        int              v;
        bit              blz;
        bit              rst_act;
        int              slot;
        logic [3:0]      exp_an;
        ld      = bus.load;
        v       = int'(bus.value);
        blz     = bus.blank_lz;
        rst_act = !rst_n;
        @(posedge clk);
        #1;
        edge_no++;
        if (rst_act) begin
            scan_n       = 0;
            m_active     = 0;
            m_pend       = 0;
            m_shown      = 0;
            m_apply_edge = -1;
        end else begin
            scan_n++;
            if (m_apply_edge == edge_no) m_shown = m_next_shown;
            if (m_active && (edge_no == m_start_edge + CONV_EDGES)) begin
                m_next_shown = m_conv_val;
                m_apply_edge = edge_no + 1;
                if (m_pend || ld) begin
                    m_conv_val   = ld ? v : m_pend_val;
                    m_pend       = 0;
                    m_start_edge = edge_no;
                end else begin
                    m_active = 0;
                end
            end else if (m_active) begin
                if (ld) begin
                    m_pend     = 1;
                    m_pend_val = v;
                end
            end else if (ld) begin
                m_active     = 1;
                m_start_edge = edge_no;
                m_conv_val   = v;
            end
        end
        slot   = (scan_n == 0) ? 0 : ((scan_n - 1) / RDIV) % 4;
        exp_an = ~(4'b0001 << slot);
        check("an", 16'(bus.AN), 16'(exp_an));
        check("busy", 16'(bus.busy), 16'(m_active));
        check("digit", 16'(bus.digit), 16'(exp_digit(m_shown, slot, blz)));
    endtask

    task automatic load_val(int v);
        bus.value = BW'(v);
        bus.load  = 1'b1;
        tick();
        bus.load  = 1'b0;
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Bounded wait for the model to go idle, then let the display settle.
    task automatic settle();
        for (int i = 0; i < 200 && m_active; i++) tick();
        run(2);
    endtask

    task automatic frame();
        run(4 * RDIV);
    endtask

    initial begin
        bus.value    = '0;
        bus.load     = 1'b0;
        bus.blank_lz = 1'b0;
        rst_n        = 1'b0;

        // Reset and free-running scan
        run(3);
        rst_n = 1'b1;
        run(4 * RDIV + 1);
        $display("reset/scan step done, edge %0d", edge_no);

        // Basic conversion with exact latency
        load_val(1234);
        settle();
        frame();
        $display("load 1234 done, edge %0d", edge_no);

        // Leading-zero blanking, live toggle, zero value
        bus.blank_lz = 1'b1;
        load_val(7);
        settle();
        frame();
        bus.blank_lz = 1'b0;
        frame();
        bus.blank_lz = 1'b1;
        load_val(0);
        settle();
        frame();
        $display("blanking steps done, edge %0d", edge_no);

        // Overflow and recovery
        load_val(10000);
        settle();
        frame();
        load_val(9999);
        settle();
        frame();
        $display("overflow steps done, edge %0d", edge_no);

        // Back-to-back loads: 2222 is superseded by 3333
        bus.blank_lz = 1'b0;
        load_val(1111);
        run(3);
        load_val(2222);
        run(4);
        load_val(3333);
        settle();
        frame();
        $display("pending steps done, edge %0d", edge_no);

        // Load arriving exactly in the commit cycle
        load_val(100);
        run(CONV_EDGES - 1);
        load_val(200);
        settle();
        frame();
        $display("commit-cycle load done, edge %0d", edge_no);

        // Reset in the middle of a conversion
        load_val(5555);
        run(6);
        rst_n = 1'b0;
        run(2);
        rst_n = 1'b1;
        frame();
        load_val(42);
        settle();
        frame();
        $display("mid-conversion reset done, edge %0d", edge_no);

        // Randomized loads, including during busy, with blanking toggles
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 11) == 0) begin
                case ($urandom_range(0, 3))
                    0: bus.value = BW'($urandom_range(0, 16383));
                    1: bus.value = BW'($urandom_range(0, 99));
                    2: bus.value = BW'($urandom_range(9990, 10010));
                    default: bus.value = BW'($urandom_range(0, 9999));
                endcase
                bus.load = 1'b1;
            end
            if ($urandom_range(0, 19) == 0) bus.blank_lz = ~bus.blank_lz;
            tick();
            bus.load = 1'b0;
        end
        settle();
        frame();
        $display("random phase done, edge %0d", edge_no);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Scan controller for the four-digit seven-segment display. It accepts a binary value on a load strobe and converts it to four BCD digits with a sequential double-dabble engine. It then time-multiplexes those digits onto the shared cathode bus at a divided refresh rate, driving the active-low anode enables. It sits between the application logic and the existing `binary_to_segment` decoder, which consumes the 5-bit digit code produced here.

## Interface
Parameters:
- `REFRESH_DIV`, default 100000: clocks per digit slot. At 100 MHz this gives 1 kHz per digit and 250 Hz per frame. Must be ≥ 2.
- `BIN_W`, default 14: width of the binary input.

Ports:
- `clk`, input, 1: single clock domain; everything is sampled on the rising edge.
- `rst_n`, input, 1: synchronous reset, active-low.
- `value`, input, `BIN_W`: binary number to display, sampled when `load` is high.
- `load`, input, 1: single-cycle request to display `value`.
- `blank_lz`, input, 1: when 1, leading zeros are blanked.
- `busy`, output, 1: a conversion is in progress.
- `AN`, output, 4: anode enables, active-low, one-hot-zero.
- `digit`, output, 5: digit code to `binary_to_segment`. Codes 0–9 are decimal digits, `SEG_BLANK` (5'h10) is all segments off, and `SEG_DASH` (5'h11) is the middle segment only.

## Operation
- Reset (`rst_n` = 0 at an edge):
  - `AN` = 4'b1110, `digit` = 0, `busy` = 0.
  - Prescaler = 0, scan index = 0.
  - Display registers = 0000, overflow flag = 0, pending flag = 0.
  - FSM goes to IDLE.
  - Reset mid-conversion abandons the conversion. The display shows 0.
- Conversion FSM:
  - IDLE → SHIFT on `load`. Capture `value` and clear the BCD shift register.
  - SHIFT: runs exactly `BIN_W` iterations. Each iteration first adds 3 to every BCD nibble ≥ 5, then shifts {bcd, bin} left by 1. After the last iteration, go to COMMIT.
  - COMMIT: write the four BCD nibbles into the display registers in one cycle, so the update is atomic and no partial value is ever shown.
    - If the captured value was > 9999, set overflow and leave the BCD nibbles unused.
    - If pending = 1, clear pending and go to SHIFT using the value captured by the last pending load. Otherwise go to IDLE.
- `load` while not in IDLE: set pending and overwrite the pending value register; the most recent value wins. The running conversion continues undisturbed.
- `load` in the COMMIT cycle counts as pending, not as a direct start.
- `busy` = 1 in SHIFT and COMMIT, 0 in IDLE.
- Scan:
  - The prescaler counts 0..`REFRESH_DIV`-1 and wraps to 0. The tick fires on the terminal count.
  - On each tick the scan index advances 0→1→2→3→0.
  - `AN` has bit[index] low and all others high. Digit 0 is the least significant digit.
- Digit select, registered every cycle from the scan index and the display registers:
  - If overflow = 1: `SEG_DASH` on all four digits.
  - Else if `blank_lz` = 1, index ≠ 0, and this digit and all higher digits are 0: `SEG_BLANK`.
  - Else: the BCD nibble, zero-extended.
  - Value 0 with `blank_lz` = 1 therefore shows a single "0".
- `blank_lz` is live. A change affects `digit` on the next edge and needs no conversion.

## Timing
- `load` sampled at edge k (IDLE):
  - `busy` = 1 after edge k.
  - SHIFT covers edges k+1 .. k+`BIN_W`.
  - COMMIT is at edge k+`BIN_W`+1; the display registers update there and `busy` falls at that edge.
  - `digit` reflects the new value after edge k+`BIN_W`+2.
- Back-to-back loads: the pending conversion starts at the edge after COMMIT, so there is one COMMIT cycle with no idle gap.
- `AN` and `digit` change on the same edge. They are both registered, so there is no glitching between them.
- The prescaler and scan index are independent of the FSM. A conversion never stalls or resets scanning.

## Structure
- Shared package `seg_pkg`:
  - `SEG_BLANK` = 5'h10, `SEG_DASH` = 5'h11, `NUM_DIGITS` = 4, `BCD_MAX` = 9999.
  - FSM state enum {IDLE, SHIFT, COMMIT}.
- Sub-module `bin2bcd_seq`: the double-dabble engine. It has `start`, `bin`, `bcd[15:0]`, `done` and an iteration counter sized `$clog2(BIN_W+1)`.
- The top level holds the prescaler, scan index, display/overflow/pending registers and the digit mux.

## Test plan
Bench uses `REFRESH_DIV` = 4, `BIN_W` = 14.
- Reset with `rst_n` low for 3 cycles → `AN` = 1110, `digit` = 0, `busy` = 0. After release, `AN` steps 1110→1101→1011→0111→1110, with a step every 4 clocks.
- `load` 1234 at edge k → `busy` high for 15 cycles. After edge k+16, `digit` is 4, 3, 2, 1 in `AN` slots 0–3.
- `load` 7 with `blank_lz` = 1 → digits are 7, BLANK, BLANK, BLANK. Toggle `blank_lz` to 0 → 7, 0, 0, 0 on the next edge. `load` 0 with `blank_lz` = 1 → 0, BLANK, BLANK, BLANK.
- `load` 10000 → all four slots show `SEG_DASH`. Then `load` 9999 → 9, 9, 9, 9 and overflow clears.
- `load` 1111, then `load` 2222 and `load` 3333 while busy → display goes 1111 then 3333; 2222 never appears. `busy` stays high continuously across both conversions.
- Assert `rst_n` = 0 in the middle of SHIFT for `load` 5555 → display stays 0000, `busy` = 0, and the next `load` 42 converts correctly.
